// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - two-port round-robin/fixed-priority front end sharing one fp32 adder
// Contains the combinational fp_adder (RNE) and the fp_add_arbiter top.

module fp_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);
  logic        a_nan, b_nan, a_inf, b_inf, swap, eff_sub, rnd;
  logic [31:0] x, y;
  logic [7:0]  ex_eff, ey_eff, d, e_base;
  logic [23:0] mx, my;
  logic [26:0] my_sh, norm;
  logic [53:0] wide;
  logic [27:0] sum;
  logic [4:0]  pos, lz;
  logic [9:0]  e_res;
  logic [30:0] packed_v, rounded;

  always_comb begin
    a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    // x always carries the larger magnitude so the subtraction never goes negative
    swap    = b[30:0] > a[30:0];
    x       = swap ? b : a;
    y       = swap ? a : b;
    ex_eff  = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey_eff  = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx      = {x[30:23] != 8'd0, x[22:0]};
    my      = {y[30:23] != 8'd0, y[22:0]};
    d       = ex_eff - ey_eff;
    wide    = 54'd0;
    if (d > 8'd26) begin
      my_sh = {26'd0, |my};
    end else begin
      wide  = {my, 3'b000, 27'd0} >> d;
      my_sh = wide[53:27] | {26'd0, |wide[26:0]};
    end
    eff_sub = x[31] ^ y[31];
    sum     = eff_sub ? ({1'b0, mx, 3'b000} - {1'b0, my_sh})
                      : ({1'b0, mx, 3'b000} + {1'b0, my_sh});
    pos = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) pos = 5'(i);
    end
    lz = 5'd26 - pos;
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      e_res = {2'b00, ex_eff} + 10'd1;
    end else if ({5'd0, lz} >= {2'b00, ex_eff}) begin
      // result is subnormal: shift only down to exponent 1 and encode field 0
      norm  = sum[26:0] << (ex_eff - 8'd1);
      e_res = 10'd0;
    end else begin
      norm  = sum[26:0] << lz;
      e_res = {2'b00, ex_eff} - {5'd0, lz};
    end
    // hidden bit (norm[26]) is added back into the exponent field by the packed sum
    e_base   = e_res[7:0] - {7'd0, norm[26]};
    rnd      = norm[2] & (norm[1] | norm[0] | norm[3]);
    packed_v = {e_base, 23'd0} + {7'd0, norm[26:3]};
    rounded  = packed_v + {30'd0, rnd};
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) s = 32'h7FC0_0000;
    else if (a_inf)                                            s = a;
    else if (b_inf)                                            s = b;
    else if (sum == 28'd0)                                     s = {x[31] & ~eff_sub, 31'd0};
    else if (e_res >= 10'd255)                                 s = {x[31], 8'hFF, 23'd0};
    else                                                       s = {x[31], rounded};
  end
endmodule

module fp_add_arbiter #(
  parameter int PRIO_RR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_s,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_s,
  output logic        busy,
  output logic [15:0] op_cnt0,
  output logic [15:0] op_cnt1
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state, state_nxt;
  logic        last_srv, owner, grant0, grant1, req_hs, rsp_hs;
  logic [31:0] op_a, op_b, res, sum;

  fp_adder u_add (.a(op_a), .b(op_b), .s(sum));

  // last_srv=1 means port 1 was served last, so port 0 takes the next tie
  assign grant0 = req0_valid & (~req1_valid | (PRIO_RR == 0) | last_srv);
  assign grant1 = req1_valid & ~grant0;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_s     = 32'd0;
    rsp1_s     = 32'd0;
    req_hs     = 1'b0;
    rsp_hs     = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        req_hs     = grant0 | grant1;
        if (req_hs) state_nxt = EXEC;
      end
      EXEC: state_nxt = DONE;
      DONE: begin
        if (owner) begin
          rsp1_valid = 1'b1;
          rsp1_s     = res;
          rsp_hs     = rsp1_ready;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_s     = res;
          rsp_hs     = rsp0_ready;
        end
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= 32'd0;
      op_b     <= 32'd0;
      res      <= 32'd0;
      owner    <= 1'b0;
      last_srv <= 1'b1;
      op_cnt0  <= 16'd0;
      op_cnt1  <= 16'd0;
    end else begin
      if (req_hs) begin
        op_a     <= grant1 ? req1_a : req0_a;
        op_b     <= grant1 ? req1_b : req0_b;
        owner    <= grant1;
        last_srv <= grant1;
      end
      if (state == EXEC) res <= sum;
      if (rsp_hs) begin
        if (owner) op_cnt1 <= op_cnt1 + 16'd1;
        else       op_cnt0 <= op_cnt0 + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - directed self-checking bench for fp_add_arbiter
module tb_fp_add_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_s, rsp1_s;
  logic        busy;
  logic [15:0] op_cnt0, op_cnt1;

  logic        f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
  logic        f_rsp0_valid, f_rsp0_ready, f_rsp1_valid, f_rsp1_ready;
  logic [31:0] f_rsp0_s, f_rsp1_s;
  logic        f_busy;
  logic [15:0] f_cnt0, f_cnt1;

  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fp_add_arbiter #(.PRIO_RR(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_s(rsp0_s),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_s(rsp1_s),
    .busy(busy), .op_cnt0(op_cnt0), .op_cnt1(op_cnt1)
  );

  fp_add_arbiter #(.PRIO_RR(0)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(32'h3F80_0000), .req0_b(32'h3F80_0000),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(32'h3F80_0000), .req1_b(32'h3F80_0000),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(f_rsp0_ready), .rsp0_s(f_rsp0_s),
    .rsp1_valid(f_rsp1_valid), .rsp1_ready(f_rsp1_ready), .rsp1_s(f_rsp1_s),
    .busy(f_busy), .op_cnt0(f_cnt0), .op_cnt1(f_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic p, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input string tag);
    @(posedge clk); #1;
    if (p) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; rsp1_ready = 1'b1;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; rsp0_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, "_ready"}, p ? req1_ready : req0_ready, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check({tag, "_busy"}, busy, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_valid"}, p ? rsp1_valid : rsp0_valid, 32'd1);
    check({tag, "_sum"}, p ? rsp1_s : rsp0_s, e);
    check({tag, "_other_valid"}, p ? rsp0_valid : rsp1_valid, 32'd0);
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, f0, f1, last_c;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
    f_req0_valid = 1'b0; f_req1_valid = 1'b0; f_rsp0_ready = 1'b0; f_rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 32'd0);
    check("rst_rsp0_valid", rsp0_valid, 32'd0);
    check("rst_rsp1_valid", rsp1_valid, 32'd0);
    check("rst_rsp0_s", rsp0_s, 32'd0);
    check("rst_cnt0", op_cnt0, 32'd0);
    check("rst_cnt1", op_cnt1, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single request, operands changed after the handshake, then back-pressure
    req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000;
    @(negedge clk);
    check("single_req0_ready", req0_ready, 32'd1);
    check("single_req1_ready", req1_ready, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req0_a = 32'hDEAD_BEEF;
    @(negedge clk);
    check("single_exec_busy", busy, 32'd1);
    check("single_exec_rsp0_valid", rsp0_valid, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("single_rsp0_valid", rsp0_valid, 32'd1);
    check("single_rsp0_s", rsp0_s, 32'h4040_0000);
    check("single_rsp1_valid", rsp1_valid, 32'd0);
    check("single_rsp1_s", rsp1_s, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_rsp0_valid", rsp0_valid, 32'd1);
      check("bp_rsp0_s", rsp0_s, 32'h4040_0000);
      check("bp_busy", busy, 32'd1);
      check("bp_req0_ready", req0_ready, 32'd0);
      check("bp_req1_ready", req1_ready, 32'd0);
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    @(negedge clk);
    check("bp_release_busy", busy, 32'd0);
    check("bp_release_cnt0", op_cnt0, 32'd1);
    check("bp_release_rsp0_valid", rsp0_valid, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_cnt0_once", op_cnt0, 32'd1);

    // cancellation on port 1
    run_op(1'b1, 32'h3FC0_0000, 32'hBF00_0000, 32'h3F80_0000, "cancel_a");
    run_op(1'b1, 32'h4000_0000, 32'hC000_0000, 32'h0000_0000, "cancel_b");
    check("cancel_cnt1", op_cnt1, 32'd2);

    // continuous contention: round-robin dut vs fixed-priority u_fix
    req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000;
    req1_a = 32'h3F80_0000; req1_b = 32'h3F80_0000;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    f_req0_valid = 1'b1; f_req1_valid = 1'b1; f_rsp0_ready = 1'b1; f_rsp1_ready = 1'b1;
    n = 0; f0 = 0; f1 = 0; last_c = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      @(negedge clk);
      if (f_req0_ready) f0++;
      if (f_req1_ready) f1++;
      if (rsp0_valid) check("rr_rsp0_s", rsp0_s, 32'h4000_0000);
      if (rsp1_valid) check("rr_rsp1_s", rsp1_s, 32'h4000_0000);
      if (req0_ready || req1_ready) begin
        check("rr_grant", req1_ready, 32'(n % 2));
        if (n > 0) check("rr_spacing", 32'(c - last_c), 32'd3);
        last_c = c;
        n++;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    check("rr_accepts", 32'(n), 32'd8);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rr_cnt0", op_cnt0, 32'd5);
    check("rr_cnt1", op_cnt1, 32'd6);
    check("fix_grants0", 32'(f0), 32'd8);
    check("fix_grants1", 32'(f1), 32'd0);
    check("fix_cnt0", f_cnt0, 32'd8);
    check("fix_cnt1", f_cnt1, 32'd0);
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0; f_rsp0_ready = 1'b0; f_rsp1_ready = 1'b0;

    // reset pulse while port 0 op is in EXEC
    req0_valid = 1'b1; req0_a = 32'h4040_0000; req0_b = 32'h3F80_0000;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("mid_exec_busy", busy, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 32'd0);
    check("mid_rst_cnt0", op_cnt0, 32'd0);
    check("mid_rst_cnt1", op_cnt1, 32'd0);
    check("mid_rst_rsp0_valid", rsp0_valid, 32'd0);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_rsp0_valid", rsp0_valid, 32'd0);
      check("post_rst_busy", busy, 32'd0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("post_rst_tie_req0", req0_ready, 32'd1);
    check("post_rst_tie_req1", req1_ready, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
